mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter and block-fill sequencer placed between the I-cache and D-cache miss handlers and the single shared 4-cycle main memory. It grants one requester at a time and runs it to completion. A fill streams 8 sequential word addresses into the pipelined memory and returns the words, with word indices, to the owning cache. D-side traffic has priority over I-side because the M-stage instruction is older; single-word data write-throughs also go through this block.

## Interface
Parameters:
- MEM_LAT, 4, memory read latency in cycles (address issue to mem_data_valid)
- WORDS, 8, 16-bit words per cache block (16-byte block)

Ports (clk, rst_n: one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  I-cache block miss; held until i_done
- i_addr  in  16  I miss address; block base = i_addr[15:4]
- d_req  in  1  D-cache block miss; held until d_done
- d_addr  in  16  D miss address
- d_wr  in  1  D write-through request; held until wr_ack
- d_wr_addr  in  16  write address
- d_wr_data  in  16  write data
- mem_en  out  1  memory access enable
- mem_wr  out  1  memory write (valid with mem_en)
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_data_valid  in  1  mem_rdata valid this cycle
- fill_data  out  16  returned word (= mem_rdata)
- fill_word  out  3  word index within the block
- i_fill_we  out  1  write fill_data into I-cache data array
- d_fill_we  out  1  write fill_data into D-cache data array
- i_done  out  1  one-cycle pulse: I fill complete
- d_done  out  1  one-cycle pulse: D fill complete
- wr_ack  out  1  one-cycle pulse: write issued
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WRITE, FILL, DONE.
- IDLE: arbitration by fixed priority d_wr > d_req > i_req.
  - Winner's address is latched and owner is recorded (I or D).
  - d_wr goes to WRITE; d_req or i_req goes to FILL with issue_cnt = 0 and recv_cnt = 0.
  - No request: stay in IDLE.
  - mem_data_valid is ignored in IDLE.
- WRITE (1 cycle): mem_en = 1, mem_wr = 1, mem_addr and mem_wdata from latched write; wr_ack = 1. Next state is IDLE.
- FILL:
  - While issue_cnt < WORDS: mem_en = 1, mem_wr = 0, mem_addr = {base[15:4], issue_cnt[2:0], 1'b0}, and issue_cnt increments.
  - On each mem_data_valid: fill_word = recv_cnt, owner's fill_we = 1, recv_cnt increments.
  - Valid on recv_cnt == WORDS-1 moves to DONE.
  - The block counts valids and does not depend on MEM_LAT being exact.
- DONE (1 cycle): the owner's done pulse is asserted, then IDLE. Requesters deassert req in the cycle after done, because the tag is written on done, so there is no re-grant.
- Owner and address are latched at grant. Requests that change or drop mid-fill are ignored; the fill always completes.
- A pending d_wr or d_req during an I fill waits. It wins at the next IDLE.
- The block adds no combinational path from any request input to any memory output.

## Timing
- Reset (async, any state, including mid-fill):
  - State goes to IDLE; counters clear; owner = D.
  - All outputs are 0, except fill_data, which follows mem_rdata.
  - In-flight memory responses after reset are dropped (IDLE ignores valid).
- Grant latency: a request sampled in IDLE at cycle t enters WRITE or FILL at t+1.
- Fill: addresses are issued on cycles t+1 through t+8, one per cycle, back-to-back.
  - Word k is valid at t+1+k+MEM_LAT.
  - Done pulse at t+9+MEM_LAT (t+13 with default).
  - Next grant is possible at t+14 (IDLE at t+14, grant sampled there).
- Write: wr_ack and the memory write occur at t+1. The next arbitration is at t+2.
- i_fill_we, d_fill_we, i_done, d_done and wr_ack are mutually exclusive every cycle.
- Counter widths are $clog2(WORDS)+1. issue_cnt saturates at WORDS; recv_cnt does not wrap within a fill.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, WRITE, FILL, DONE);
  - the owner enum (OWN_I, OWN_D);
  - BLOCK_OFFSET_W = 4 and WORD_IDX_W = 3.
- Single module. The issue and receive counters and the FSM are inline; no sub-module is warranted.

## Test plan
- Lone I miss: i_req=1, i_addr=16'h0046 → mem_addr 16'h0040…16'h004E on 8 consecutive cycles; i_fill_we with fill_word 0..7; i_done at t+13; d_fill_we never high.
- Simultaneous d_req (d_addr=16'h1234) and i_req → D fill of 16'h1230–16'h123E first with d_done; I fill starts the cycle after the following IDLE.
- d_wr (addr 16'h2000, data 16'hBEEF) with d_req and i_req all high → WRITE first: mem_wr=1, mem_addr=16'h2000, mem_wdata=16'hBEEF, wr_ack; then the D fill.
- i_req dropped at fill cycle 3 → all 8 words still written, i_done pulses, busy falls after DONE.
- rst_n asserted after 5 words received → outputs 0 immediately; post-reset mem_data_valid pulses produce no fill_we; a new i_req is granted normally.
- MEM_LAT=6 instance → identical address sequence; done moves to t+15.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the I/D memory arbiter and block-fill sequencer.
package mem_arb_pkg;

  localparam int unsigned ADDR_W         = 16;
  localparam int unsigned DATA_W         = 16;
  localparam int unsigned BLOCK_OFFSET_W = 4;
  localparam int unsigned WORD_IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (d_wr > d_req > i_req) that runs one write-through or
// one 8-word block fill at a time against a pipelined shared memory.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 4,
  parameter int unsigned WORDS   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic                  d_req,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic                  d_wr,
  input  logic [ADDR_W-1:0]     d_wr_addr,
  input  logic [DATA_W-1:0]     d_wr_data,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_data_valid,
  output logic [DATA_W-1:0]     fill_data,
  output logic [WORD_IDX_W-1:0] fill_word,
  output logic                  i_fill_we,
  output logic                  d_fill_we,
  output logic                  i_done,
  output logic                  d_done,
  output logic                  wr_ack,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(WORDS) + 1;

  // Only 8-word blocks with a non-zero memory latency are meaningful here;
  // the fill counts returned words, so the exact latency is otherwise unused.
  if (MEM_LAT == 0 || WORDS != (1 << WORD_IDX_W)) begin : g_unsupported_cfg
  end

  state_e              r_state,  w_state_nxt;
  owner_e              r_owner,  w_owner_nxt;
  logic [ADDR_W-1:0]   r_addr,   w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata,  w_wdata_nxt;
  logic [CNT_W-1:0]    r_issue_cnt, w_issue_nxt;
  logic [CNT_W-1:0]    r_recv_cnt,  w_recv_nxt;

  // Returned word goes straight to whichever cache owns the fill.
  assign fill_data = mem_rdata;

  // State, grant record and fill counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= OWN_D;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_issue_cnt <= w_issue_nxt;
      r_recv_cnt  <= w_recv_nxt;
    end
  end

  // Arbitration, address issue, fill return steering and completion pulses.
  // Memory outputs depend only on registered state, never on request inputs.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_issue_nxt = r_issue_cnt;
    w_recv_nxt  = r_recv_cnt;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_word   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_done      = 1'b0;
    d_done      = 1'b0;
    wr_ack      = 1'b0;
    busy        = (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (d_wr) begin
          w_state_nxt = WRITE;
          w_owner_nxt = OWN_D;
          w_addr_nxt  = d_wr_addr;
          w_wdata_nxt = d_wr_data;
        end else if (d_req) begin
          w_state_nxt = FILL;
          w_owner_nxt = OWN_D;
          w_addr_nxt  = d_addr;
          w_issue_nxt = '0;
          w_recv_nxt  = '0;
        end else if (i_req) begin
          w_state_nxt = FILL;
          w_owner_nxt = OWN_I;
          w_addr_nxt  = i_addr;
          w_issue_nxt = '0;
          w_recv_nxt  = '0;
        end
      end

      WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = r_addr;
        mem_wdata   = r_wdata;
        wr_ack      = 1'b1;
        w_state_nxt = IDLE;
      end

      FILL: begin
        if (r_issue_cnt < CNT_W'(WORDS)) begin
          mem_en      = 1'b1;
          mem_addr    = {r_addr[ADDR_W-1:BLOCK_OFFSET_W],
                         r_issue_cnt[WORD_IDX_W-1:0], 1'b0};
          w_issue_nxt = r_issue_cnt + CNT_W'(1);
        end
        if (mem_data_valid) begin
          fill_word  = r_recv_cnt[WORD_IDX_W-1:0];
          i_fill_we  = (r_owner == OWN_I);
          d_fill_we  = (r_owner == OWN_D);
          w_recv_nxt = r_recv_cnt + CNT_W'(1);
          if (r_recv_cnt == CNT_W'(WORDS - 1)) begin
            w_state_nxt = DONE;
          end
        end
      end

      DONE: begin
        i_done      = (r_owner == OWN_I);
        d_done      = (r_owner == OWN_D);
        w_state_nxt = IDLE;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default instance plus a MEM_LAT=6 instance,
// each fed by a pipelined memory model returning addr ^ 16'h5A5A.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // Default-latency instance signals.
  logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wr_addr = '0, d_wr_data = '0;
  logic        mem_en, mem_wr, mem_data_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_done, d_done, wr_ack, busy;

  // MEM_LAT=6 instance signals.
  logic        i_req6 = 1'b0, d_req6 = 1'b0, d_wr6 = 1'b0;
  logic [15:0] i_addr6 = '0, d_addr6 = '0, d_wr_addr6 = '0, d_wr_data6 = '0;
  logic        mem_en6, mem_wr6, mem_data_valid6;
  logic [15:0] mem_addr6, mem_wdata6, mem_rdata6, fill_data6;
  logic [2:0]  fill_word6;
  logic        i_fill_we6, d_fill_we6, i_done6, d_done6, wr_ack6, busy6;

  mem_arbiter #(.MEM_LAT(4), .WORDS(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_addr(d_addr),
    .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_done(i_done), .d_done(d_done), .wr_ack(wr_ack), .busy(busy)
  );

  mem_arbiter #(.MEM_LAT(6), .WORDS(8)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req6), .i_addr(i_addr6), .d_req(d_req6), .d_addr(d_addr6),
    .d_wr(d_wr6), .d_wr_addr(d_wr_addr6), .d_wr_data(d_wr_data6),
    .mem_en(mem_en6), .mem_wr(mem_wr6), .mem_addr(mem_addr6), .mem_wdata(mem_wdata6),
    .mem_rdata(mem_rdata6), .mem_data_valid(mem_data_valid6),
    .fill_data(fill_data6), .fill_word(fill_word6),
    .i_fill_we(i_fill_we6), .d_fill_we(d_fill_we6),
    .i_done(i_done6), .d_done(d_done6), .wr_ack(wr_ack6), .busy(busy6)
  );

  // Pipelined memory models; reads only, not reset, so in-flight data survives rst_n.
  logic [3:0]  v4 = '0;
  logic [15:0] a4 [4] = '{default: '0};
  logic [5:0]  v6 = '0;
  logic [15:0] a6 [6] = '{default: '0};

  always @(posedge clk) begin
    v4 <= {v4[2:0], mem_en & ~mem_wr};
    a4[0] <= mem_addr;
    for (int i = 1; i < 4; i++) a4[i] <= a4[i-1];
    v6 <= {v6[4:0], mem_en6 & ~mem_wr6};
    a6[0] <= mem_addr6;
    for (int i = 1; i < 6; i++) a6[i] <= a6[i-1];
  end

  assign mem_data_valid  = v4[3];
  assign mem_rdata       = a4[3] ^ 16'h5A5A;
  assign mem_data_valid6 = v6[5];
  assign mem_rdata6      = a6[5] ^ 16'h5A5A;

  // Observation mux so one fill checker serves both instances.
  logic        sel = 1'b0;
  logic        o_en, o_wr, o_ifwe, o_dfwe, o_idone, o_ddone, o_ack, o_busy;
  logic [15:0] o_addr, o_data;
  logic [2:0]  o_word;

  always_comb begin
    o_en    = sel ? mem_en6    : mem_en;
    o_wr    = sel ? mem_wr6    : mem_wr;
    o_addr  = sel ? mem_addr6  : mem_addr;
    o_data  = sel ? fill_data6 : fill_data;
    o_word  = sel ? fill_word6 : fill_word;
    o_ifwe  = sel ? i_fill_we6 : i_fill_we;
    o_dfwe  = sel ? d_fill_we6 : d_fill_we;
    o_idone = sel ? i_done6    : i_done;
    o_ddone = sel ? d_done6    : d_done;
    o_ack   = sel ? wr_ack6    : wr_ack;
    o_busy  = sel ? busy6      : busy;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Quiescent outputs expected in IDLE (or under reset).
  task automatic check_idle(input string tag);
    check({tag, ":mem_en"},    32'(o_en),    32'(0));
    check({tag, ":mem_addr"},  32'(o_addr),  32'(0));
    check({tag, ":i_fill_we"}, 32'(o_ifwe),  32'(0));
    check({tag, ":d_fill_we"}, 32'(o_dfwe),  32'(0));
    check({tag, ":i_done"},    32'(o_idone), 32'(0));
    check({tag, ":d_done"},    32'(o_ddone), 32'(0));
    check({tag, ":wr_ack"},    32'(o_ack),   32'(0));
    check({tag, ":busy"},      32'(o_busy),  32'(0));
  endtask

  task automatic drop_req(input bit is_i);
    if (sel) i_req6 = 1'b0;
    else if (is_i) i_req = 1'b0;
    else d_req = 1'b0;
  endtask

  // Checks a fill cycle by cycle starting at its first FILL cycle (c=1).
  // Addresses at c=1..8, word k at c=1+k+lat, done at c=9+lat.
  task automatic fill_seq(input bit is_i, input logic [15:0] base, input int lat,
                          input int drop_at, input int stop_at);
    bit en_e, we_e, done_e;
    for (int c = 1; c <= stop_at; c++) begin
      en_e   = (c <= 8);
      we_e   = (c >= 1 + lat) && (c <= 8 + lat);
      done_e = (c == 9 + lat);
      check("mem_en", 32'(o_en), 32'(en_e));
      if (en_e) begin
        check("mem_wr",   32'(o_wr),   32'(0));
        check("mem_addr", 32'(o_addr), 32'(base + 16'(2 * (c - 1))));
      end
      check("i_fill_we", 32'(o_ifwe), 32'(we_e && is_i));
      check("d_fill_we", 32'(o_dfwe), 32'(we_e && !is_i));
      if (we_e) begin
        check("fill_word", 32'(o_word), 32'(c - 1 - lat));
        check("fill_data", 32'(o_data), 32'((base + 16'(2 * (c - 1 - lat))) ^ 16'h5A5A));
      end
      check("i_done", 32'(o_idone), 32'(done_e && is_i));
      check("d_done", 32'(o_ddone), 32'(done_e && !is_i));
      check("wr_ack", 32'(o_ack),   32'(0));
      check("busy",   32'(o_busy),  32'(1));
      if (c == drop_at || done_e) drop_req(is_i);
      tick();
    end
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check_idle("rst");
    check("rst:fill_word", 32'(fill_word), 32'(0));
    check("rst:fill_data", 32'(fill_data), 32'(mem_rdata));
    rst_n = 1'b1;
    tick();
    check_idle("post_rst");

    // Lone I miss
    i_addr = 16'h0046; i_req = 1'b1;
    tick();
    fill_seq(1'b1, 16'h0040, 4, 0, 13);
    check_idle("s1_end");

    // Simultaneous D and I miss: D first, then I after one IDLE cycle
    d_addr = 16'h1234; d_req = 1'b1;
    i_addr = 16'h0046; i_req = 1'b1;
    tick();
    fill_seq(1'b0, 16'h1230, 4, 0, 13);
    check_idle("s2_gap");
    tick();
    fill_seq(1'b1, 16'h0040, 4, 0, 13);
    check_idle("s2_end");

    // Write-through beats both fills
    d_wr = 1'b1; d_wr_addr = 16'h2000; d_wr_data = 16'hBEEF;
    d_addr = 16'h3008; d_req = 1'b1;
    i_addr = 16'h0046; i_req = 1'b1;
    tick();
    check("wr:mem_en",    32'(mem_en),    32'(1));
    check("wr:mem_wr",    32'(mem_wr),    32'(1));
    check("wr:mem_addr",  32'(mem_addr),  32'(16'h2000));
    check("wr:mem_wdata", 32'(mem_wdata), 32'(16'hBEEF));
    check("wr:wr_ack",    32'(wr_ack),    32'(1));
    check("wr:busy",      32'(busy),      32'(1));
    check("wr:d_fill_we", 32'(d_fill_we), 32'(0));
    d_wr = 1'b0;
    tick();
    check_idle("s3_arb");
    tick();
    fill_seq(1'b0, 16'h3000, 4, 0, 13);
    check_idle("s3_gap");
    tick();
    fill_seq(1'b1, 16'h0040, 4, 0, 13);
    check_idle("s3_end");

    // I request dropped mid-fill: fill still completes, no re-grant
    i_addr = 16'h0F1E; i_req = 1'b1;
    tick();
    fill_seq(1'b1, 16'h0F10, 4, 3, 13);
    check_idle("s4_end");
    tick();
    check_idle("s4_hold");

    // Reset after 5 words received; remaining responses must be dropped
    i_addr = 16'h4400; i_req = 1'b1;
    tick();
    fill_seq(1'b1, 16'h4400, 4, 0, 9);
    rst_n = 1'b0; i_req = 1'b0;
    #1;
    check_idle("s5_rst");
    check("s5_rst:fill_word", 32'(fill_word), 32'(0));
    check("s5_rst:fill_data", 32'(fill_data), 32'(mem_rdata));
    tick();
    check_idle("s5_rst_hold");
    rst_n = 1'b1;
    #1;
    check_idle("s5_release");
    tick();
    check_idle("s5_drop7");
    tick();
    check_idle("s5_quiet");
    i_addr = 16'h5552; i_req = 1'b1;
    tick();
    fill_seq(1'b1, 16'h5550, 4, 0, 13);
    check_idle("s5_end");

    // MEM_LAT=6 instance: same addresses, done at t+15
    sel = 1'b1;
    i_addr6 = 16'h0046; i_req6 = 1'b1;
    tick();
    fill_seq(1'b1, 16'h0040, 6, 0, 15);
    check_idle("s6_end");
    sel = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_mem_arbiter
